// File: rtl/pwm_sine_sequencer.sv
// Frame-level PWM sine sequencer: owns the frame counter and a phase accumulator walking a
// sine duty table; duty changes only on frame boundaries and a stop always drains the frame.
module pwm_sine_sequencer #(
    parameter int PERIOD     = 1000,
    parameter int LUT_DEPTH  = 64,
    parameter int WIDTH_BITS = 10,
    parameter int PHASE_BITS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         step_load,
    input  logic [PHASE_BITS-1:0]        step_in,
    output logic                         pwm_out,
    output logic [WIDTH_BITS-1:0]        duty,
    output logic                         frame_tick,
    output logic [$clog2(LUT_DEPTH)-1:0] sample_idx,
    output logic                         running
);
    localparam int IDX_BITS = $clog2(LUT_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [WIDTH_BITS-1:0] frame_cnt, frame_cnt_nxt;
    logic [PHASE_BITS-1:0] phase_acc, phase_nxt, phase_sum;
    logic [PHASE_BITS-1:0] step_active, step_active_nxt;
    logic [PHASE_BITS-1:0] step_pending, step_pending_nxt;
    logic [PHASE_BITS-1:0] step_sel;
    logic                  pend_valid, pend_valid_nxt;
    logic [WIDTH_BITS-1:0] duty_nxt;
    logic                  boundary;
    logic [WIDTH_BITS-1:0] lut [LUT_DEPTH];

    function automatic logic [WIDTH_BITS-1:0] lut_val(input int k);
        real half;
        real ang;
        real v;
        half = real'(PERIOD) / 2.0;
        ang  = 2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_DEPTH);
        v    = $floor(half + (half - 1.0) * $sin(ang));
        return WIDTH_BITS'($rtoi(v));
    endfunction

    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
        assign lut[k] = lut_val(k);
    end

    assign boundary   = (frame_cnt == WIDTH_BITS'(PERIOD - 1));
    assign running    = (state != IDLE);
    assign frame_tick = running && boundary;
    assign sample_idx = phase_acc[PHASE_BITS-1 -: IDX_BITS];

    // A strobe coinciding with the boundary wins over any pending value.
    assign step_sel  = step_load ? step_in : (pend_valid ? step_pending : step_active);
    assign phase_sum = phase_acc + step_sel;

    always_comb begin
        state_nxt        = state;
        frame_cnt_nxt    = frame_cnt;
        phase_nxt        = phase_acc;
        step_active_nxt  = step_active;
        step_pending_nxt = step_pending;
        pend_valid_nxt   = pend_valid;
        duty_nxt         = duty;

        if (step_load) begin
            step_pending_nxt = step_in;
            pend_valid_nxt   = 1'b1;
        end

        case (state)
            IDLE: begin
                frame_cnt_nxt = '0;
                if (enable) begin
                    state_nxt = RUN;
                    phase_nxt = '0;
                    duty_nxt  = lut[0];
                end
            end
            RUN, DRAIN: begin
                frame_cnt_nxt = boundary ? '0 : frame_cnt + WIDTH_BITS'(1);
                if (state == RUN && !enable) begin
                    state_nxt = DRAIN;
                end
                if (state == DRAIN && boundary) begin
                    state_nxt = IDLE;
                end
                if (state == RUN && boundary) begin
                    phase_nxt        = phase_sum;
                    step_active_nxt  = step_sel;
                    step_pending_nxt = step_pending;
                    pend_valid_nxt   = 1'b0;
                    duty_nxt         = lut[phase_sum[PHASE_BITS-1 -: IDX_BITS]];
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            frame_cnt    <= '0;
            phase_acc    <= '0;
            step_active  <= '0;
            step_pending <= '0;
            pend_valid   <= 1'b0;
            duty         <= '0;
            pwm_out      <= 1'b0;
        end else begin
            state        <= state_nxt;
            frame_cnt    <= frame_cnt_nxt;
            phase_acc    <= phase_nxt;
            step_active  <= step_active_nxt;
            step_pending <= step_pending_nxt;
            pend_valid   <= pend_valid_nxt;
            duty         <= duty_nxt;
            pwm_out      <= (state != IDLE) && (frame_cnt < duty);
        end
    end
endmodule

// File: tb/tb_pwm_sine_sequencer.sv
// Bench for pwm_sine_sequencer: per-frame table of step loads/stops/resets, expected frame
// duty/index pushed to a scoreboard and checked by a monitor at every frame_tick.
module tb_pwm_sine_sequencer;
    localparam int PERIOD    = 1000;
    localparam int LUT_DEPTH = 64;
    localparam int NF        = 83;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        step_load;
    logic [15:0] step_in;
    logic        pwm_out;
    logic [9:0]  duty;
    logic        frame_tick;
    logic [5:0]  sample_idx;
    logic        running;

    pwm_sine_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .step_load  (step_load),
        .step_in    (step_in),
        .pwm_out    (pwm_out),
        .duty       (duty),
        .frame_tick (frame_tick),
        .sample_idx (sample_idx),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int duty;
        int idx;
    } exp_t;

    typedef struct {
        int l1_at;
        int l1_val;
        int l2_at;
        int l2_val;
        int adv;
        int drop_at;
        int rst_at;
    } frame_vec_t;

    exp_t       sb [$];
    frame_vec_t tbl [NF];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         hi_cnt = 0;
    int         cyc_cnt = 0;

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int exp_duty(int idx);
        real v;
        case (idx)
            0, 32:   return 500;
            16:      return 999;
            48:      return 1;
            default: begin
                v = $floor(500.0 + 499.0 * $sin(2.0 * 3.14159265358979323846 * real'(idx) / 64.0));
                return $rtoi(v);
            end
        endcase
    endfunction

    // Frame monitor: pwm_out lags frame_cnt by one cycle, so counting from the cycle after one
    // tick through the next tick covers exactly one frame's high period.
    always @(negedge clk) begin
        exp_t e;
        if (!running) begin
            hi_cnt  = 0;
            cyc_cnt = 0;
        end else begin
            cyc_cnt++;
            if (pwm_out) hi_cnt++;
            if (frame_tick) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("frame_duty", int'(duty), e.duty);
                    check("frame_idx", int'(sample_idx), e.idx);
                    check("pwm_high_cnt", hi_cnt, e.duty);
                    check("tick_spacing", cyc_cnt, PERIOD);
                end
                hi_cnt  = 0;
                cyc_cnt = 0;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   idx_exp;
        bit   aborted;
        exp_t e;

        for (int f = 0; f < NF; f++) begin
            tbl[f] = '{l1_at: -1, l1_val: 0, l2_at: -1, l2_val: 0, adv: 1, drop_at: -1, rst_at: -1};
        end
        tbl[70] = '{l1_at: 300, l1_val: 2048, l2_at: 400, l2_val: 4096, adv: 4, drop_at: -1, rst_at: -1};
        tbl[71].adv = 4;
        tbl[72] = '{l1_at: 100, l1_val: 1024, l2_at: 999, l2_val: 3072, adv: 3, drop_at: -1, rst_at: -1};
        tbl[73].adv = 3;
        tbl[74] = '{l1_at: 999, l1_val: 0, l2_at: -1, l2_val: 0, adv: 0, drop_at: -1, rst_at: -1};
        tbl[75].adv = 0;
        tbl[76].rst_at = 700;
        tbl[77].l1_at  = 50;
        tbl[77].l1_val = 1024;
        tbl[82].drop_at = 200;

        rst = 1'b1;
        enable = 1'b0;
        step_load = 1'b0;
        step_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_duty", int'(duty), 0);
        check("reset_idx", int'(sample_idx), 0);
        check("reset_running", int'(running), 0);
        check("reset_tick", int'(frame_tick), 0);
        rst = 1'b0;

        // Step loaded while idle must wait for the first boundary, not apply at start.
        step_load = 1'b1;
        step_in = 16'd1024;
        @(posedge clk);
        #1;
        step_load = 1'b0;
        check("idle_load_running", int'(running), 0);
        enable = 1'b1;
        @(posedge clk);
        #1;

        idx_exp = 0;
        for (int f = 0; f < NF; f++) begin
            e.duty = exp_duty(idx_exp);
            e.idx  = idx_exp;
            sb.push_back(e);
            aborted = 1'b0;
            for (int c = 0; c < PERIOD; c++) begin
                step_load = 1'b0;
                if (f == 0 && c == 0) begin
                    check("start_running", int'(running), 1);
                    check("start_pwm_lag", int'(pwm_out), 0);
                end
                if (f == 0 && c == 1) check("start_pwm_first", int'(pwm_out), 1);
                if (c == tbl[f].l1_at) begin
                    step_load = 1'b1;
                    step_in = 16'(tbl[f].l1_val);
                end
                if (c == tbl[f].l2_at) begin
                    step_load = 1'b1;
                    step_in = 16'(tbl[f].l2_val);
                end
                if (c == tbl[f].drop_at) enable = 1'b0;
                if (tbl[f].drop_at >= 0 && c == tbl[f].drop_at + 200) enable = 1'b1;
                if (tbl[f].drop_at >= 0 && c == tbl[f].drop_at + 205) enable = 1'b0;
                if (c == tbl[f].rst_at) begin
                    check("pre_rst_pwm", int'(pwm_out), 1);
                    check("pre_rst_running", int'(running), 1);
                    #2;
                    rst = 1'b1;
                    #1;
                    check("mid_rst_pwm", int'(pwm_out), 0);
                    check("mid_rst_duty", int'(duty), 0);
                    check("mid_rst_idx", int'(sample_idx), 0);
                    check("mid_rst_running", int'(running), 0);
                    check("mid_rst_tick", int'(frame_tick), 0);
                    sb.delete();
                    repeat (2) @(posedge clk);
                    #1;
                    rst = 1'b0;
                    @(posedge clk);
                    #1;
                    aborted = 1'b1;
                    break;
                end
                @(posedge clk);
                #1;
            end
            step_load = 1'b0;
            if (aborted) idx_exp = 0;
            else idx_exp = (idx_exp + tbl[f].adv) % LUT_DEPTH;
        end

        // Last table frame drained after enable dropped: no update at its boundary.
        check("stop_running", int'(running), 0);
        check("stop_pwm_0", int'(pwm_out), 0);
        check("stop_tick", int'(frame_tick), 0);
        @(posedge clk);
        #1;
        check("stop_pwm_1", int'(pwm_out), 0);
        check("stop_idx_held", int'(sample_idx), 5);
        check("stop_duty_held", int'(duty), exp_duty(5));
        repeat (20) @(posedge clk);
        #1;
        check("idle_stays", int'(running), 0);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
